// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among NUM_REQ consumers.
// Each grant pops up to BURST_LEN words (1 when nearly empty) with registered delivery.
module fifo_read_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic                  rempty,
   input  logic                  ralmost_empty,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  rinc,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [NUM_REQ-1:0]    dout_valid,
   output logic                  busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [IW:0]   NREQ_W = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0] LAST   = IW'(NUM_REQ - 1);
   localparam logic [CW-1:0] BL_W   = CW'(BURST_LEN);
   localparam logic [CW-1:0] ONE_W  = CW'(1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                  state_q, state_d;
   logic [NUM_REQ-1:0]      gnt_q, gnt_d;
   logic [IW-1:0]           owner_q, owner_d;
   logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]           limit_q, limit_d;
   logic [CW-1:0]           pop_cnt_q, pop_cnt_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic [NUM_REQ-1:0]      dout_valid_q, dout_valid_d;

   logic                    sel_vld;
   logic [IW-1:0]           sel_idx;
   logic                    owner_req;

   // First requester at or after rr_ptr, scanning with wraparound.
   always_comb begin
      logic [IW:0] pos;
      sel_vld = 1'b0;
      sel_idx = '0;
      pos     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = {1'b0, rr_ptr_q} + (IW+1)'(i);
         if (pos >= NREQ_W) pos = pos - NREQ_W;
         if (!sel_vld && req[pos[IW-1:0]]) begin
            sel_vld = 1'b1;
            sel_idx = pos[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      limit_d      = limit_q;
      pop_cnt_d    = pop_cnt_q;
      dout_d       = dout_q;
      dout_valid_d = '0;
      busy         = (state_q == BURST);
      owner_req    = req[owner_q];
      rinc         = busy & ~rrst & ~rempty & owner_req & (pop_cnt_q < limit_q);

      if (rinc) begin
         dout_d       = rdata;
         dout_valid_d = gnt_q;
         pop_cnt_d    = pop_cnt_q + ONE_W;
      end

      case (state_q)
         IDLE: begin
            if (sel_vld && !rempty) begin
               state_d   = BURST;
               owner_d   = sel_idx;
               limit_d   = ralmost_empty ? ONE_W : BL_W;
               pop_cnt_d = '0;
               for (int i = 0; i < NUM_REQ; i++) gnt_d[i] = (sel_idx == IW'(i));
            end
         end
         BURST: begin
            // pop_cnt_d already includes this cycle's pop.
            if (rempty || !owner_req || (rinc && (pop_cnt_d == limit_q))) begin
               state_d  = IDLE;
               gnt_d    = '0;
               rr_ptr_d = (owner_q == LAST) ? '0 : owner_q + IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         limit_q      <= '0;
         pop_cnt_q    <= '0;
         dout_q       <= '0;
         dout_valid_q <= '0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         limit_q      <= limit_d;
         pop_cnt_q    <= pop_cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign gnt        = gnt_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Randomised and directed bench for fifo_read_arbiter against a per-burst
// behavioural model, a FIFO model and an in-order delivery scoreboard.
module tb_fifo_read_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BL = 4;

   logic          rclk = 1'b0;
   logic          rrst = 1'b1;
   logic [N-1:0]  req = '0;
   logic          rempty = 1'b1;
   logic          ralmost_empty = 1'b1;
   logic [DW-1:0] rdata = '0;
   logic          rinc;
   logic [N-1:0]  gnt;
   logic [DW-1:0] dout;
   logic [N-1:0]  dout_valid;
   logic          busy;

   fifo_read_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .rclk(rclk), .rrst(rrst), .req(req), .rempty(rempty),
      .ralmost_empty(ralmost_empty), .rdata(rdata), .rinc(rinc), .gnt(gnt),
      .dout(dout), .dout_valid(dout_valid), .busy(busy)
   );

   always #5 rclk = ~rclk;

   int n_cmp = 0;
   int n_fail = 0;

   // FIFO contents and words not yet delivered, in push order
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] sb_q[$];
   int            ae_th = 1;

   // Burst-level model state
   bit            m_busy = 1'b0;
   int            m_owner = 0;
   int            m_limit = 0;
   int            m_pops = 0;
   int            m_ptr = 0;
   logic [N-1:0]  m_dv = '0;
   logic [DW-1:0] m_dout = '0;
   int            gnt_log[$];
   int            pops_log[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word();
      logic [DW-1:0] w;
      w = DW'($urandom);
      fifo_q.push_back(w);
      sb_q.push_back(w);
   endtask

   task automatic drive_fifo();
      rempty        = (fifo_q.size() == 0);
      rdata         = rempty ? '0 : fifo_q[0];
      ralmost_empty = (fifo_q.size() <= ae_th);
   endtask

   task automatic model_step(input bit rst, input logic [N-1:0] r, input bit emp,
                             input bit ae, input logic [DW-1:0] rd, input bit ri);
      logic [N-1:0] one;
      bit found;
      int idx;
      one = 1;
      if (rst) begin
         if (m_busy) pops_log.push_back(m_pops);
         m_busy = 0; m_ptr = 0; m_pops = 0; m_dv = '0; m_dout = '0;
      end else begin
         m_dv = ri ? (one << m_owner) : '0;
         if (ri) m_dout = rd;
         if (!m_busy) begin
            if (r != 0 && !emp) begin
               found = 0;
               for (int k = 0; k < N; k++) begin
                  idx = (m_ptr + k) % N;
                  if (!found && r[idx]) begin
                     found = 1;
                     m_owner = idx;
                  end
               end
               m_limit = ae ? 1 : BL;
               m_pops  = 0;
               m_busy  = 1;
               gnt_log.push_back(m_owner);
            end
         end else begin
            if (ri) m_pops++;
            if (m_pops == m_limit || !r[m_owner] || emp) begin
               m_busy = 0;
               m_ptr  = (m_owner + 1) % N;
               pops_log.push_back(m_pops);
            end
         end
      end
   endtask

   // One clock: drive, compare against the model, cross the edge, advance model and FIFO.
   task automatic cycle(input bit rst, input logic [N-1:0] r, input int push_n);
      bit           exp_rinc, dut_pop, emp_s, ae_s;
      logic [N-1:0] exp_gnt, one;
      logic [DW-1:0] rd_s, exp_w;
      one  = 1;
      rrst = rst;
      req  = r;
      drive_fifo();
      #1;
      exp_rinc = m_busy && !rst && !rempty && r[m_owner] && (m_pops < m_limit);
      exp_gnt  = m_busy ? (one << m_owner) : '0;
      check("gnt", gnt, exp_gnt);
      check("busy", busy, m_busy);
      check("rinc", rinc, exp_rinc);
      check("dout_valid", dout_valid, m_dv);
      check("dout", dout, m_dout);
      if (dout_valid != '0) begin
         check("sb_pending", (sb_q.size() > 0), 1);
         exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
         check("sb_order", dout, exp_w);
      end
      dut_pop = rinc;
      emp_s = rempty; ae_s = ralmost_empty; rd_s = rdata;
      @(posedge rclk);
      #1;
      model_step(rst, r, emp_s, ae_s, rd_s, exp_rinc);
      if (dut_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      for (int p = 0; p < push_n; p++) push_word();
   endtask

   task automatic start_test(input int th);
      fifo_q.delete();
      sb_q.delete();
      gnt_log.delete();
      pops_log.delete();
      ae_th = th;
      cycle(1, '0, 0);
      cycle(1, '0, 0);
   endtask

   task automatic end_test();
      cycle(0, '0, 0);
      cycle(0, '0, 0);
      check("conserve", sb_q.size(), fifo_q.size());
   endtask

   task automatic preload(input int n);
      for (int i = 0; i < n; i++) push_word();
   endtask

   initial begin
      logic [N-1:0] r;
      bit rst;
      @(posedge rclk);
      #1;

      // single requester, deep FIFO: two full bursts separated by one idle cycle
      start_test(1);
      preload(10);
      cycle(0, 4'b0001, 0);
      cycle(0, 4'b0001, 0);
      check("A_gnt_lit", gnt, 4'b0001);
      repeat (10) cycle(0, 4'b0001, 0);
      check("A_nbursts", pops_log.size(), 2);
      if (pops_log.size() >= 2 && gnt_log.size() >= 2) begin
         check("A_own0", gnt_log[0], 0);
         check("A_pops0", pops_log[0], 4);
         check("A_own1", gnt_log[1], 0);
         check("A_pops1", pops_log[1], 4);
      end
      end_test();

      // all requesting, FIFO never empty: 0,1,2,3,0 with four pops each
      start_test(1);
      preload(8);
      repeat (25) cycle(0, 4'b1111, 1);
      check("B_nbursts", pops_log.size(), 5);
      if (pops_log.size() >= 5 && gnt_log.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
            check("B_owner", gnt_log[i], i % 4);
            check("B_pops", pops_log[i], 4);
         end
      end
      end_test();

      // almost-empty at grant: single-pop bursts, pointer moves past requester 2
      start_test(3);
      preload(3);
      repeat (10) cycle(0, 4'b0100, 0);
      check("C_nbursts", pops_log.size(), 3);
      if (pops_log.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            check("C_pops", pops_log[i], 1);
            check("C_owner", gnt_log[i], 2);
         end
      end
      check("C_ptr", m_ptr, 3);
      end_test();

      // burst cut short by empty, resumes once data returns
      start_test(0);
      preload(2);
      repeat (6) cycle(0, 4'b0010, 0);
      check("D_nbursts", pops_log.size(), 1);
      if (pops_log.size() >= 1) check("D_pops0", pops_log[0], 2);
      cycle(0, 4'b0010, 3);
      repeat (8) cycle(0, 4'b0010, 0);
      check("D_ngrants", gnt_log.size(), 2);
      if (gnt_log.size() >= 2 && pops_log.size() >= 2) begin
         check("D_own1", gnt_log[1], 1);
         check("D_pops1", pops_log[1], 3);
      end
      end_test();

      // owner withdraws after two pops; next grant goes round-robin
      start_test(1);
      preload(10);
      repeat (3) cycle(0, 4'b0011, 0);
      repeat (3) cycle(0, 4'b0010, 0);
      if (gnt_log.size() >= 2 && pops_log.size() >= 1) begin
         check("E_own0", gnt_log[0], 0);
         check("E_pops0", pops_log[0], 2);
         check("E_own1", gnt_log[1], 1);
      end else check("E_logs", gnt_log.size(), 2);
      end_test();

      // reset mid-burst after one pop
      start_test(1);
      preload(10);
      repeat (2) cycle(0, 4'b0001, 0);
      cycle(1, 4'b0001, 0);
      check("F_gnt", gnt, 4'b0000);
      check("F_dv", dout_valid, 4'b0000);
      check("F_dout", dout, 8'h00);
      check("F_rinc", rinc, 1'b0);
      check("F_ptr", m_ptr, 0);
      repeat (3) cycle(0, 4'b0001, 0);
      end_test();

      // random traffic with occasional resets
      start_test(1);
      preload(6);
      r = 4'b1010;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) r = N'($urandom);
         if ($urandom_range(31) == 0) ae_th = $urandom_range(3);
         rst = ($urandom_range(99) == 0);
         cycle(rst, r, ($urandom_range(3) < 2) ? 1 : 0);
      end
      end_test();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
